// File: rtl/rotating_msg_disp.sv
// rotating_msg_disp: scrolling-message driver for an NDIG-digit multiplexed 7-segment display
// Ports: clk; reset (async, active-high); en/dir/mode step controls; load/load_data message
// update; sseg (active-low, bit7 = dp) and an (active-low one-hot) display pins; pos window
// offset; wrap one-cycle step pulse; done one-shot finished flag.
// Optional: define ROT_START_MARK_EN to light the dp of the digit showing nibble 0.
module rotating_msg_disp #(
  parameter int NDIG = 4,
  parameter int MSG_LEN = 10,
  parameter logic [4*MSG_LEN-1:0] INIT_MSG = 40'h0123456789,
  parameter int DIV_W = 24,
  parameter int REF_W = 18,
  localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic [1:0]           mode,
  input  logic                 load,
  input  logic [4*MSG_LEN-1:0] load_data,
  output logic [7:0]           sseg,
  output logic [NDIG-1:0]      an,
  output logic [PW-1:0]        pos,
  output logic                 wrap,
  output logic                 done
);
  typedef enum logic {RUN, DONE} state_t;
  localparam int PMAX = MSG_LEN - NDIG;
  localparam logic [PW-1:0] LAST = PW'(MSG_LEN - 1);
  localparam logic [PW-1:0] PM = PW'(PMAX);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  function automatic int win_idx(input int p, input int d);
    int s;
    s = p + NDIG - 1 - d;
    return (s >= MSG_LEN) ? s - MSG_LEN : s;
  endfunction
  function automatic logic [7:0] seg_of(input logic [4*MSG_LEN-1:0] m, input int p, input int d);
    int i;
    i = win_idx(p, d);
`ifdef ROT_START_MARK_EN
    return {i != 0, HEX[m[4*(MSG_LEN-1-i) +: 4]]};
`else
    return {1'b1, HEX[m[4*(MSG_LEN-1-i) +: 4]]};
`endif
  endfunction
  state_t state;
  logic [DIV_W-1:0] presc;
  logic [REF_W-1:0] rcnt;
  logic [4*MSG_LEN-1:0] msg;
  logic bdir;
  logic tick, step, rot_w, wrap_n, bdir_n, fin;
  logic [PW-1:0] rot_p, pos_n;
  logic [SW-1:0] sel, dig;
  assign tick = &presc;
  assign step = tick & en & (state == RUN) & (mode != 2'd3);
  assign rot_w = dir ? (pos == LAST) : (pos == '0);
  assign rot_p = dir ? ((pos == LAST) ? '0 : pos + 1'b1) : ((pos == '0) ? LAST : pos - 1'b1);
  assign sel = rcnt[REF_W-1 -: SW];
  // Select codes beyond the last digit (non power-of-2 NDIG) fall back to digit 0.
  assign dig = (int'(sel) < NDIG) ? sel : '0;
  // Bounce reverses at the window limits; an out-of-range pos restarts the sweep at 0.
  always_comb begin
    pos_n = rot_p;
    wrap_n = rot_w;
    bdir_n = bdir;
    fin = 1'b0;
    if (mode == 2'd1) begin
      if (PMAX == 0 || pos > PM) begin
        pos_n = '0;
        wrap_n = 1'b0;
        bdir_n = 1'b1;
      end else if (bdir) begin
        pos_n = (pos == PM) ? PM - 1'b1 : pos + 1'b1;
        wrap_n = (pos == PM);
        bdir_n = (pos != PM);
      end else begin
        pos_n = (pos == '0) ? PW'(1) : pos - 1'b1;
        wrap_n = (pos == '0);
        bdir_n = (pos == '0);
      end
    end else if (mode == 2'd2 && rot_w) begin
      pos_n = '0;
      fin = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc <= '0;
      rcnt <= '0;
      msg <= INIT_MSG;
      pos <= '0;
      bdir <= 1'b1;
      state <= RUN;
      wrap <= 1'b0;
      done <= 1'b0;
      an <= ~NDIG'(1);
      sseg <= seg_of(INIT_MSG, 0, 0);
    end else begin
      rcnt <= rcnt + 1'b1;
      an <= ~(NDIG'(1) << dig);
      sseg <= seg_of(msg, int'(pos), int'(dig));
      if (load) begin
        msg <= load_data;
        pos <= '0;
        presc <= '0;
        bdir <= 1'b1;
        state <= RUN;
        done <= 1'b0;
        wrap <= 1'b0;
      end else begin
        presc <= presc + 1'b1;
        wrap <= step & wrap_n;
        if (step) begin
          pos <= pos_n;
          bdir <= bdir_n;
          if (fin) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
      end
    end
endmodule

// File: doc/rotating_msg_disp.md
Name: rotating_msg_disp

Overview:
- Parametrised scrolling-message driver for an NDIG-digit multiplexed 7-segment display.
- Holds a MSG_LEN-nibble message and shows an NDIG-nibble window into it.
- The window steps on a prescaled tick in one of three modes: wrap-around rotate, bounce, or one-shot.
- Contains its own prescaler, digit refresh multiplexer and hex-to-segment decode; it drives the board's sseg/an pins directly.

Parameters:
- NDIG, 4: number of display digits (2..8).
- MSG_LEN, 10: message length in nibbles; must be >= NDIG.
- INIT_MSG, 40'h0123456789: reset message, 4*MSG_LEN bits; nibble 0 is the MSB nibble.
- DIV_W, 24: step prescaler width; one tick every 2^DIV_W clk cycles.
- REF_W, 18: refresh counter width; digit select is bits [REF_W-1 -: clog2(NDIG)].

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  step enable; the prescaler runs regardless.
- dir  in  1  1 = step left (pos+1), 0 = step right (pos-1).
- mode  in  2  0 = rotate, 1 = bounce, 2 = one-shot, 3 = freeze (window held).
- load  in  1  single-cycle pulse: latch load_data.
- load_data  in  4*MSG_LEN  new message.
- sseg  out  8  active-low segments; bit7 = dp, bits6:0 = g..a.
- an  out  NDIG  active-low one-hot digit enable.
- pos  out  clog2(MSG_LEN)  current window offset.
- wrap  out  1  one-cycle pulse when pos steps across the MSG_LEN-1/0 boundary (rotate/one-shot) or reverses (bounce).
- done  out  1  one-shot finished flag.

Behaviour:
- Reset values: msg = INIT_MSG, pos = 0, prescaler = 0, refresh counter = 0, bounce direction bdir = forward, state = RUN.
- Reset outputs: wrap = 0, done = 0, an = ~1 (digit 0 lit), sseg = decode of the window nibble for digit 0.
- Window mapping: physical digit d (d = NDIG-1 is leftmost) shows nibble index (pos + NDIG-1-d) mod MSG_LEN.
- Prescaler: free-running DIV_W-bit up-counter. tick = 1 in the cycle it equals all-ones.
- A step occurs on tick && en && state == RUN && mode != 3. pos updates on the clk edge ending that cycle; latency is 1 cycle from tick.
- Rotate mode: dir=1 gives pos = (pos+1) mod MSG_LEN; dir=0 gives pos = (pos == 0) ? MSG_LEN-1 : pos-1. wrap pulses on the 9->0 or 0->9 transition (MSG_LEN = 10).
- Bounce mode: dir is ignored and bdir is used. PMAX = MSG_LEN-NDIG.
  - bdir forward and pos == PMAX: bdir flips, pos = PMAX-1, wrap pulses.
  - bdir backward and pos == 0: bdir flips, pos = 1, wrap pulses.
  - pos > PMAX on a step (e.g. after a mode change): pos = 0, bdir = forward, no wrap pulse.
  - PMAX == 0: pos stays 0 and no wrap pulses.
- One-shot mode: steps as in rotate mode. On the step that wraps, the state goes RUN -> DONE with pos = 0, done = 1 and wrap pulses once.
  - DONE is left only by load or reset.
  - Changing mode while in DONE does not clear done.
- Freeze mode (mode = 3): pos, bdir and state are held. The prescaler and refresh keep running.
- Load: pulse latches load_data and sets pos = 0, prescaler = 0, bdir = forward, state = RUN, done = 0.
  - Load has priority over a step in the same cycle; that step is discarded and wrap = 0.
  - The new message is visible the cycle after load.
- Refresh: the REF_W counter free-runs. The digit select indexes NDIG digits; when NDIG is not a power of 2, select values >= NDIG show digit 0. an/sseg are registered, so they appear 1 cycle after the select changes.
- Decode: standard active-low hex 0-F; dp = 1 (off) unless the optional feature is enabled.
- All state is asynchronously reset; there are no combinational paths from inputs to sseg/an.

Optional Feature:
- Macro: ROT_START_MARK_EN.
- Defined: the dp of whichever physical digit is currently showing nibble index 0 is driven low (lit), marking the message start. When nibble 0 is not in the window, no dp is lit.
- Undefined: sseg[7] = 1 at all times.

Test Plan:
- Reset with DIV_W=2, default message, mode=0, dir=1, en=1 -> after 4 clks pos=1; window nibbles 1,2,3,4; after 40 clks pos=0 and wrap pulsed once.
- mode=0, dir=0 from pos=0 -> first step gives pos=9 with wrap=1; the leftmost digit shows 9 and the rightmost shows 2.
- mode=1, MSG_LEN=10, NDIG=4 -> pos sequence 0,1,...,6,5,...,0,1; wrap pulses when pos goes 6->5 and when it goes 0->1.
- mode=2, dir=1 -> 10 steps, then done=1 and pos=0 held for 40+ further clks; a load pulse with load_data=40'hABCDEF0123 gives done=0, pos=0 and window A,B,C,D.
- load asserted in the same cycle as tick -> pos=0, wrap=0, and the prescaler restarts from 0.
- Refresh check with REF_W=4 -> an cycles 1110, 1101, 1011, 0111, each held 4 clks, and the sseg decode matches the window. With ROT_START_MARK_EN defined and pos=0, sseg[7]=0 only while an=0111.
